// File: rtl/serdes_pkg.sv
// Shared encodings and helpers for the serializer and the SIPO-side framing logic.
package serdes_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load port and frame strobes.
// Handshake: a word transfers when load_valid && load_ready at a rising clk edge.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = CNT_W(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             in_shift;

  assign in_shift = (state == ST_SHIFT);
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // Ready in idle and on the last bit, so a waiting word follows with no bubble.
  assign load_ready   = !in_shift || last_bit;
  assign serial_valid = in_shift;
  assign busy         = in_shift;
  assign serial_out   = in_shift ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_LEVEL;
  assign frame_start  = in_shift && (bit_cnt == '0);
  assign frame_last   = in_shift && last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shift_reg[WIDTH-1:1]};
            bit_cnt   <= bit_cnt + CW'(1);
          end else if (load_valid) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
          end else begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer with a valid/ready load handshake and frame markers. It sits directly upstream of the team's 4-bit SIPO register (sipo_reg_beh): it accepts a parallel word and emits it one bit per clock on `serial_out`, which drives the SIPO's `data_in`. The `frame_start`/`frame_last` strobes give the downstream stage the word alignment the bare SIPO lacks. Back-to-back words stream with no idle bubble.

## Interface
- `WIDTH`, default 4: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- `IDLE_LEVEL`, default 0: value driven on `serial_out` when no frame is active.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  upstream offers `data_in` this cycle.
- `load_ready`  out  1  block accepts a word this cycle; transfer = `load_valid && load_ready` at the rising edge.
- `data_in`  in  WIDTH  parallel word to serialize.
- `serial_out`  out  1  current serial bit; connects to SIPO `data_in`.
- `serial_valid`  out  1  `serial_out` carries a frame bit this cycle.
- `frame_start`  out  1  first bit of a frame is on `serial_out`.
- `frame_last`  out  1  last bit of a frame is on `serial_out`.
- `busy`  out  1  a frame is in progress; equals `serial_valid`.

## Operation
- State: FSM `{IDLE, SHIFT}`, `shift_reg[WIDTH-1:0]`, `bit_cnt[$clog2(WIDTH)-1:0]`.
- Reset (async, `rst`=1) forces state IDLE, `shift_reg`=0 and `bit_cnt`=0. Outputs during and after reset:
  - `serial_out`=IDLE_LEVEL
  - `serial_valid`=`frame_start`=`frame_last`=`busy`=0
  - `load_ready`=1
- No transfer is taken while `rst` is high.
- IDLE:
  - `load_ready`=1.
  - On transfer: `shift_reg`←`data_in`, `bit_cnt`←0, go to SHIFT.
- SHIFT:
  - `serial_out` = `shift_reg[WIDTH-1]` when MSB_FIRST=1, else `shift_reg[0]`.
  - `serial_valid`=1.
  - `frame_start` = (`bit_cnt`==0).
  - `frame_last` = (`bit_cnt`==WIDTH-1).
- While `bit_cnt` < WIDTH-1:
  - Shift toward the output end, filling with 0.
  - `bit_cnt`++.
  - `load_ready`=0; `load_valid` is ignored, and `data_in` is not sampled.
- When `bit_cnt`==WIDTH-1:
  - `load_ready`=1.
  - On transfer: reload `shift_reg`, `bit_cnt`←0, stay in SHIFT (back-to-back).
  - Otherwise: go to IDLE.
- All outputs are decoded from registered state only. There is no combinational path from `load_valid` or `data_in` to any output.
- `bit_cnt` never exceeds WIDTH-1. It does not wrap within a frame; it returns to 0 only on a reload.

## Timing
- Word accepted at edge N → first bit on `serial_out` in cycle N+1 (1-cycle latency).
- Last bit is in cycle N+WIDTH.
- Frame length is exactly WIDTH cycles. Sustained throughput is 1 word per WIDTH cycles with `load_valid` held high.
- `load_ready` is high in IDLE and in the last-bit cycle of each frame, so a waiting word is accepted in the same cycle the last bit is shown.
- Downstream SIPO capture: a WIDTH-bit SIPO sampling on the same edges holds the complete word after the edge ending the `frame_last` cycle.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). The partial word is discarded. The next accepted word starts a fresh frame at `bit_cnt`=0.
- `load_valid` may drop or `data_in` may change at any time when `load_ready`=0 with no effect.

## Structure
- Shared package `serdes_pkg` holds:
  - state encodings `ST_IDLE`=1'b0 and `ST_SHIFT`=1'b1, reused by the SIPO-side framing logic;
  - the counter-width helper `CNT_W(WIDTH)` = `$clog2(WIDTH)`.
- Single module; no sub-module. Counter, shift register and FSM live together.

## Test plan
- Reset: hold `rst`=1 for 2 cycles, with `load_valid`=1 and `data_in`=4'hF throughout → `serial_valid`=0, `serial_out`=0 and `load_ready`=1 for both cycles; nothing is accepted.
- Single word, WIDTH=4, MSB_FIRST=1: load 4'b1011 at edge 0 →
  - `serial_out` = 1,0,1,1 in cycles 1–4;
  - `frame_start` only in cycle 1, `frame_last` only in cycle 4;
  - `serial_valid`=0 and `serial_out`=IDLE_LEVEL from cycle 5.
- Back-to-back: `load_valid` held with 4'b1011 then 4'b0110 →
  - 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no bubble;
  - `frame_start` in cycles 1 and 5;
  - second word accepted at the edge ending cycle 4.
- Load during frame: present 4'b1111 with `load_valid` in cycles 2–4 of a frame → `load_ready`=0 in cycles 2–3; word accepted only at the edge ending cycle 4 and appears as 1,1,1,1 in cycles 5–8.
- Reset mid-frame: assert `rst` during cycle 2 of 4'b1011 → `serial_valid` drops immediately and the partial word is discarded. After `rst` is released, load 4'b0101 → 0,1,0,1 with `frame_start` on its first bit.
- LSB-first: MSB_FIRST=0, load 4'b1011 → `serial_out` = 1,1,0,1.
